// File: rtl/keypad_value_encoder_pkg.sv
// Shared definitions for the keypad value encoder: scan codes,
// display sentinels, FSM states and small arithmetic helpers.
package keypad_value_encoder_pkg;

    // PS/2 set-2 make codes for the decimal digits 0..9
    localparam logic [7:0] KEY_D0    = 8'h45;
    localparam logic [7:0] KEY_D1    = 8'h16;
    localparam logic [7:0] KEY_D2    = 8'h1E;
    localparam logic [7:0] KEY_D3    = 8'h26;
    localparam logic [7:0] KEY_D4    = 8'h25;
    localparam logic [7:0] KEY_D5    = 8'h2E;
    localparam logic [7:0] KEY_D6    = 8'h36;
    localparam logic [7:0] KEY_D7    = 8'h3D;
    localparam logic [7:0] KEY_D8    = 8'h3E;
    localparam logic [7:0] KEY_D9    = 8'h46;

    // Control keys
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_BKSP  = 8'h66;
    localparam logic [7:0] KEY_ESC   = 8'h76;

    // Sentinels understood by the value-to-7-segment decoder
    localparam logic [13:0] DISP_EMPTY = 14'd10001;
    localparam logic [13:0] DISP_ERROR = 14'd10002;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_e;

    // Decoded key classification
    typedef struct packed {
        logic       is_digit;
        logic [3:0] digit;
        logic       is_enter;
        logic       is_bksp;
        logic       is_esc;
    } key_info_t;

    // acc*10 built from shifts; operands stay at or below 999 so the
    // 14-bit result never wraps.
    function automatic logic [13:0] mul10(input logic [13:0] a);
        return (a << 3) + (a << 1);
    endfunction

endpackage

// File: rtl/keypad_value_encoder_if.sv
// Key strobe input and display/result outputs of the keypad value encoder.
interface keypad_value_encoder_if;

    logic        key_valid;
    logic [7:0]  key_code;
    logic [13:0] disp_value;
    logic [13:0] result;
    logic        result_valid;
    logic [2:0]  digit_count;
    logic        error;

    // Upstream side: delivers key strobes, observes the encoder outputs
    modport master (
        output key_valid,
        output key_code,
        input  disp_value,
        input  result,
        input  result_valid,
        input  digit_count,
        input  error
    );

    // Encoder side
    modport slave (
        input  key_valid,
        input  key_code,
        output disp_value,
        output result,
        output result_valid,
        output digit_count,
        output error
    );

endinterface

// File: rtl/keypad_value_encoder_ps2_digit_map.sv
// Combinational classification of a PS/2 make code into digit/control keys.
module ps2_digit_map
    import keypad_value_encoder_pkg::*;
(
    input  logic [7:0] key_code,
    output key_info_t  key_info
);

    // Decode the make code; unmapped codes yield an all-zero classification
    always_comb begin
        key_info = '0;
        case (key_code)
            KEY_D0:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd0; end
            KEY_D1:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd1; end
            KEY_D2:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd2; end
            KEY_D3:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd3; end
            KEY_D4:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd4; end
            KEY_D5:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd5; end
            KEY_D6:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd6; end
            KEY_D7:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd7; end
            KEY_D8:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd8; end
            KEY_D9:    begin key_info.is_digit = 1'b1; key_info.digit = 4'd9; end
            KEY_ENTER: key_info.is_enter = 1'b1;
            KEY_BKSP:  key_info.is_bksp  = 1'b1;
            KEY_ESC:   key_info.is_esc   = 1'b1;
            default:   key_info = '0;
        endcase
    end

endmodule

// File: rtl/keypad_value_encoder.sv
// Keypad value encoder: assembles up to MAX_DIGITS decimal digits from
// PS/2 make codes into a binary value and drives a display word.
module keypad_value_encoder
    import keypad_value_encoder_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    keypad_value_encoder_if.slave bus
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    key_info_t   key_s;

    state_e      state_q, state_d;
    logic [13:0] acc_q, acc_d;
    logic [2:0]  count_q, count_d;
    logic [13:0] result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic [13:0] disp_value_q, disp_value_d;
    logic        error_q, error_d;
    logic [13:0] acc_div10;

    ps2_digit_map u_map (
        .key_code (bus.key_code),
        .key_info (key_s)
    );

    // Constant divide by ten for backspace; combinational on 14 bits
    always_comb begin
        acc_div10 = acc_q / 14'd10;
    end

    // Next-state, accumulator and registered-output logic
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        count_d        = count_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        if (bus.key_valid) begin
            case (state_q)
                EMPTY: begin
                    if (key_s.is_digit) begin
                        state_d = ENTRY;
                        acc_d   = {10'd0, key_s.digit};
                        count_d = 3'd1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ENTRY: begin
                    if (key_s.is_digit) begin
                        if (count_q < MAX_CNT) begin
                            acc_d   = mul10(acc_q) + {10'd0, key_s.digit};
                            count_d = count_q + 3'd1;
                        end else begin
                            state_d = ERROR;
                        end
                    end else if (key_s.is_bksp) begin
                        acc_d   = acc_div10;
                        count_d = count_q - 3'd1;
                        // Removing the last digit returns to the empty display
                        if (count_q == 3'd1) begin
                            state_d = EMPTY;
                            acc_d   = 14'd0;
                        end else begin
                            state_d = ENTRY;
                        end
                    end else if (key_s.is_enter) begin
                        result_d       = acc_q;
                        result_valid_d = 1'b1;
                        state_d        = DONE;
                        acc_d          = 14'd0;
                        count_d        = 3'd0;
                    end else if (key_s.is_esc) begin
                        state_d = EMPTY;
                        acc_d   = 14'd0;
                        count_d = 3'd0;
                    end else begin
                        state_d = ENTRY;
                    end
                end
                DONE: begin
                    if (key_s.is_digit) begin
                        state_d = ENTRY;
                        acc_d   = {10'd0, key_s.digit};
                        count_d = 3'd1;
                    end else if (key_s.is_esc) begin
                        state_d = EMPTY;
                        acc_d   = 14'd0;
                        count_d = 3'd0;
                    end else begin
                        state_d = DONE;
                    end
                end
                ERROR: begin
                    if (key_s.is_esc) begin
                        state_d = EMPTY;
                        acc_d   = 14'd0;
                        count_d = 3'd0;
                    end else begin
                        state_d = ERROR;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    acc_d   = 14'd0;
                    count_d = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Display word follows the state being entered so it lands with the key
        case (state_d)
            EMPTY:   disp_value_d = DISP_EMPTY;
            ENTRY:   disp_value_d = acc_d;
            DONE:    disp_value_d = result_d;
            ERROR:   disp_value_d = DISP_ERROR;
            default: disp_value_d = DISP_EMPTY;
        endcase

        error_d = (state_d == ERROR);
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= EMPTY;
            acc_q          <= 14'd0;
            count_q        <= 3'd0;
            result_q       <= 14'd0;
            result_valid_q <= 1'b0;
            disp_value_q   <= DISP_EMPTY;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            disp_value_q   <= disp_value_d;
            error_q        <= error_d;
        end
    end

    assign bus.disp_value   = disp_value_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.digit_count  = count_q;
    assign bus.error        = error_q;

endmodule
